// File: rtl/alu_pkg.sv
// Shared opcode, state and control-decode definitions for the ALU op sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic legal;
    logic op1;
    logic op2;
    logic sub;
    logic cin;
  } ctrl_t;

  function automatic ctrl_t op_decode(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_AND:  c = '{legal: 1'b1, op1: 1'b0, op2: 1'b0, sub: 1'b0, cin: 1'b0};
      OP_OR:   c = '{legal: 1'b1, op1: 1'b0, op2: 1'b1, sub: 1'b0, cin: 1'b0};
      OP_ADD:  c = '{legal: 1'b1, op1: 1'b1, op2: 1'b0, sub: 1'b0, cin: 1'b0};
      OP_SUB:  c = '{legal: 1'b1, op1: 1'b1, op2: 1'b0, sub: 1'b1, cin: 1'b1};
      OP_SLT:  c = '{legal: 1'b1, op1: 1'b1, op2: 1'b1, sub: 1'b1, cin: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: 3-bit op to legal flag and per-lane ALU controls.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic       legal,
  output logic       op1,
  output logic       op2,
  output logic       sub,
  output logic       cin
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = op_decode(op);
  end

  assign legal = ctrl.legal;
  assign op1   = ctrl.op1;
  assign op2   = ctrl.op2;
  assign sub   = ctrl.sub;
  assign cin   = ctrl.cin;

endmodule

// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for the ripple ALU: registers decoded controls, waits for the
// carry chain to settle, captures the result and presents it on the response port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [WIDTH-1:0] alu_sub,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_err
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(SETTLE_CYCLES - 1);

  logic dec_legal, dec_op1, dec_op2, dec_sub, dec_cin;

  alu_ctrl_decode u_decode (
    .op    (req_op),
    .legal (dec_legal),
    .op1   (dec_op1),
    .op2   (dec_op2),
    .sub   (dec_sub),
    .cin   (dec_cin)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d, alu_sub_q, alu_sub_d;
  logic             alu_cin_q, alu_cin_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d, rsp_cout_q, rsp_cout_d, rsp_err_q, rsp_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_sub_d    = alu_sub_q;
    alu_cin_d    = alu_cin_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (dec_legal) begin
            state_d   = S_SETTLE;
            cnt_d     = CntInit;
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_op1_d = {WIDTH{dec_op1}};
            alu_op2_d = {WIDTH{dec_op2}};
            alu_sub_d = {WIDTH{dec_sub}};
            alu_cin_d = dec_cin;
          end else begin
            state_d      = S_DONE;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_cout_d   = 1'b0;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d      = S_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_out;
          rsp_zero_d   = alu_zero;
          // The carry chain is meaningless for the logic ops.
          rsp_cout_d   = alu_cout & alu_op1_q[0];
          rsp_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Illegal ops enter DONE without valid; raise it one clock after accept.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_sub_q    <= '0;
      alu_cin_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_sub_q    <= alu_sub_d;
      alu_cin_q    <= alu_cin_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_sub    = alu_sub_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural stand-in for the 32-bit ripple ALU.
module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_op1, alu_op2, alu_sub;
  logic         alu_cin;
  logic [W-1:0] alu_out;
  logic         alu_zero, alu_cout;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_cout, rsp_err;

  int total = 0;
  int bad = 0;
  int lat;

  // Expected ALU-side state: last legal op's operands and controls.
  logic [W-1:0] prev_a = '0;
  logic [W-1:0] prev_b = '0;
  logic [3:0]   prev_ctl = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_sub    (alu_sub),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_cout   (rsp_cout),
    .rsp_err    (rsp_err)
  );

  // Environment ALU: lane controls are uniform, so lane 0 selects the function.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b ^ alu_sub} + {{W{1'b0}}, alu_cin};
    case ({alu_op1[0], alu_op2[0]})
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = alu_sum[W-1:0];
      default: alu_out = {{(W-1){1'b0}}, alu_sum[W-1]};
    endcase
    alu_zero = (alu_out == '0);
    alu_cout = alu_sum[W];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: {op1,op2,sub,cin} table and plain-arithmetic results.
  function automatic logic [3:0] ref_ctl(input logic [2:0] op);
    case (op)
      3'b000:  return 4'b0000;
      3'b001:  return 4'b0100;
      3'b010:  return 4'b1000;
      3'b110:  return 4'b1011;
      3'b111:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic z, output logic c,
                           output logic e, output logic legal);
    logic [W:0] wide;
    r = '0; c = 1'b0; e = 1'b0; legal = 1'b1;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      3'b110: begin r = a - b; c = (a >= b); end
      3'b111: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = (a >= b); end
      default: begin legal = 1'b0; e = 1'b1; end
    endcase
    z = legal && (r == '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    check({tag, "_alu_ctl"}, 64'({alu_op1, alu_op2, alu_sub, alu_cin}), 64'd0);
    check({tag, "_rsp"}, 64'({rsp_result, rsp_zero, rsp_cout, rsp_err}), 64'd0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  // Issues one op, checks latency/controls/response, optionally stalls, then completes.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic ez, ec, ee, legal;
    logic [3:0] ctl;
    ref_model(op, a, b, er, ez, ec, ee, legal);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), legal ? 64'd4 : 64'd1);
    if (legal) begin
      prev_a = a; prev_b = b; prev_ctl = ref_ctl(op);
    end
    ctl = prev_ctl;
    check({tag, "_alu_a"}, 64'(alu_a), 64'(prev_a));
    check({tag, "_alu_b"}, 64'(alu_b), 64'(prev_b));
    check({tag, "_alu_op1"}, 64'(alu_op1), 64'({W{ctl[3]}}));
    check({tag, "_alu_op2"}, 64'(alu_op2), 64'({W{ctl[2]}}));
    check({tag, "_alu_sub"}, 64'(alu_sub), 64'({W{ctl[1]}}));
    check({tag, "_alu_cin"}, 64'(alu_cin), 64'(ctl[0]));
    check({tag, "_result"}, 64'(rsp_result), 64'(er));
    check({tag, "_zero"}, 64'(rsp_zero), 64'(ez));
    check({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
    check({tag, "_err"}, 64'(rsp_err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      // A competing request must be ignored while the response is pending.
      req_valid = 1'b1; req_op = 3'b010; req_a = $urandom; req_b = $urandom;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_hold_result"}, 64'(rsp_result), 64'(er));
      check({tag, "_hold_alu_a"}, 64'(alu_a), 64'(prev_a));
    end
    req_valid = 1'b0;
    handshake(tag);
    if (hold > 0) begin
      @(posedge clk); #1;
      check({tag, "_no_extra_rsp"}, 64'(rsp_valid), 64'd0);
      check({tag, "_still_idle"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    logic [2:0] ops [8];
    logic [2:0] op;
    logic [W-1:0] a, b;
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    do_op("add", 3'b010, 32'd40, 32'd10, 0);
    do_op("sub_eq", 3'b110, 32'd400, 32'd400, 0);
    do_op("slt", 3'b111, 32'd10, 32'd40, 0);
    do_op("and", 3'b000, 32'd60, 32'd30, 0);
    do_op("or", 3'b001, 32'd60, 32'd30, 0);
    do_op("illegal", 3'b100, 32'd7, 32'd9, 0);
    do_op("backpressure", 3'b010, 32'hFFFF_FFFF, 32'd2, 10);

    // Reset in the middle of SETTLE abandons the op.
    req_valid = 1'b1; req_op = 3'b010; req_a = 32'd5; req_b = 32'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_settle_rst");
    #2 rst_n = 1'b1;
    prev_a = '0; prev_b = '0; prev_ctl = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_op("after_rst_add", 3'b010, 32'd400000000, 32'd100000000, 0);

    for (int i = 0; i < 16; i++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = a;
      if (op == 3'b111) begin
        a = a & 32'h3FFF_FFFF;
        b = b & 32'h3FFF_FFFF;
      end
      do_op("rand", op, a, b, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
